// File: rtl/clock_ctrl_pkg.sv
// Shared types and limits for the clock setting controller.
// Holds the FSM state enum (its code is shown on the display as edit_field),
// the BCD digit type, the two-digit field type and the hour/minute wrap limits.
package clock_ctrl_pkg;

    typedef logic [3:0] bcd_t;

    // Two-digit BCD field: tens digit (shi) and ones digit (ge).
    typedef struct packed {
        bcd_t shi;
        bcd_t ge;
    } bcd2_t;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_SEC  = 3'd3,
        ST_ALM_HOUR = 3'd4,
        ST_ALM_MIN  = 3'd5
    } state_e;

    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;

    localparam bcd2_t HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
    localparam bcd2_t MIN_MAX_BCD  = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

endpackage

// File: rtl/bcd_wrap_inc.sv
// Two-digit BCD increment with wrap to 00 after the given maximum.
// Ports: i_tens/i_ones  value to increment
//        i_max_tens/i_max_ones  largest legal value (wraps to 00 above it)
//        o_tens/o_ones  incremented value (combinational)
module bcd_wrap_inc
    import clock_ctrl_pkg::*;
(
    input  bcd_t i_tens,
    input  bcd_t i_ones,
    input  bcd_t i_max_tens,
    input  bcd_t i_max_ones,
    output bcd_t o_tens,
    output bcd_t o_ones
);

    always_comb begin
        o_tens = i_tens;
        o_ones = i_ones + 4'd1;
        if ((i_tens == i_max_tens) && (i_ones == i_max_ones)) begin
            o_tens = 4'd0;
            o_ones = 4'd0;
        end else if (i_ones == 4'd9) begin
            o_tens = i_tens + 4'd1;
            o_ones = 4'd0;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock setting / alarm controller for a BCD digital clock.
// Key-driven edit FSM (RUN, SET_HOUR/MIN/SEC, ALM_HOUR/MIN) editing a time
// shadow and an alarm shadow, load strobe to the time counter, alarm enable,
// ring/silence handling with auto-silence timeout, and a 2 Hz edit blink.
// Ports: clk, rst_n (async active-low); key_mode/key_inc/key_ok key pulses;
//        cur_* running BCD time; alarm_n match latch (low = matched);
//        set_time_finish + set_* time load; clock_en + clock_* effective alarm;
//        edit_field state code; blink; buzzer.
// Optional feature macro: CLOCK_SNOOZE_EN (key_inc while ringing snoozes).
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 500000,
    parameter int unsigned RING_SEC      = 30,
    parameter int unsigned SNOOZE_MIN    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_ok,
    input  logic [3:0] cur_hour_shi,
    input  logic [3:0] cur_hour_ge,
    input  logic [3:0] cur_min_shi,
    input  logic [3:0] cur_min_ge,
    input  logic [3:0] cur_sec_shi,
    input  logic [3:0] cur_sec_ge,
    input  logic       alarm_n,
    output logic       set_time_finish,
    output logic [3:0] set_hour_shi,
    output logic [3:0] set_hour_ge,
    output logic [3:0] set_min_shi,
    output logic [3:0] set_min_ge,
    output logic [3:0] set_sec_shi,
    output logic [3:0] set_sec_ge,
    output logic       clock_en,
    output logic [3:0] clock_hour_shi,
    output logic [3:0] clock_hour_ge,
    output logic [3:0] clock_min_shi,
    output logic [3:0] clock_min_ge,
    output logic [2:0] edit_field,
    output logic       blink,
    output logic       buzzer
);

    localparam int unsigned BLINK_CYC = (TICKS_PER_SEC / 4 > 0) ? TICKS_PER_SEC / 4 : 1;
    localparam int unsigned BLINK_W   = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam int unsigned RING_CYC  = (RING_SEC * TICKS_PER_SEC > 0) ? RING_SEC * TICKS_PER_SEC : 1;
    localparam int unsigned RING_W    = (RING_CYC > 1) ? $clog2(RING_CYC) : 1;

    if ((SNOOZE_MIN < 1) || (SNOOZE_MIN > 9)) begin : g_snooze_range
        $error("clock_set_ctrl: SNOOZE_MIN must be within 1..9");
    end

    state_e             r_state, w_next;
    bcd2_t              r_sh_hour, r_sh_min, r_sh_sec;
    bcd2_t              r_ash_hour, r_ash_min;
    bcd2_t              r_alm_hour, r_alm_min;
    bcd2_t              r_set_hour, r_set_min, r_set_sec;
    logic               r_finish, r_alm_en, r_silence, r_clock_en, r_buzzer, r_blink;
    logic [BLINK_W-1:0] r_tick;
    logic [RING_W-1:0]  r_ring_cnt;

    logic  w_ok, w_mode, w_inc, w_ringing, w_snooze, w_is_set, w_is_alm;
    logic  w_alm_en_nxt, w_sil_nxt;
    bcd2_t w_fld, w_fld_max, w_fld_inc, w_cur_min;

    // Key priority: ok > mode > inc.
    assign w_ok      = key_ok;
    assign w_mode    = key_mode & ~key_ok;
    assign w_inc     = key_inc & ~key_ok & ~key_mode;
    assign w_ringing = ~alarm_n & r_clock_en;
    assign w_is_set  = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN) || (r_state == ST_SET_SEC);
    assign w_is_alm  = (r_state == ST_ALM_HOUR) || (r_state == ST_ALM_MIN);
    assign w_cur_min = {cur_min_shi, cur_min_ge};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        if (w_ok) begin
            w_next = ST_RUN;
        end else if (w_mode) begin
            case (r_state)
                ST_RUN:      w_next = ST_SET_HOUR;
                ST_SET_HOUR: w_next = ST_SET_MIN;
                ST_SET_MIN:  w_next = ST_SET_SEC;
                ST_SET_SEC:  w_next = ST_ALM_HOUR;
                ST_ALM_HOUR: w_next = ST_ALM_MIN;
                default:     w_next = ST_RUN;
            endcase
        end
    end

    // Field under edit and its wrap limit.
    always_comb begin
        w_fld     = r_sh_hour;
        w_fld_max = HOUR_MAX_BCD;
        case (r_state)
            ST_SET_MIN:  begin w_fld = r_sh_min;  w_fld_max = MIN_MAX_BCD; end
            ST_SET_SEC:  begin w_fld = r_sh_sec;  w_fld_max = MIN_MAX_BCD; end
            ST_ALM_HOUR: w_fld = r_ash_hour;
            ST_ALM_MIN:  begin w_fld = r_ash_min; w_fld_max = MIN_MAX_BCD; end
            default:     ;
        endcase
    end

    bcd_wrap_inc u_fld_inc (
        .i_tens     (w_fld.shi),
        .i_ones     (w_fld.ge),
        .i_max_tens (w_fld_max.shi),
        .i_max_ones (w_fld_max.ge),
        .o_tens     (w_fld_inc.shi),
        .o_ones     (w_fld_inc.ge)
    );

    // Alarm enable / silence. Silence is released once the running minute
    // leaves the user alarm minute, so a silenced alarm cannot re-trigger.
    always_comb begin
        w_alm_en_nxt = r_alm_en;
        w_sil_nxt    = r_silence;
        if (r_silence && (w_cur_min != r_alm_min)) w_sil_nxt = 1'b0;
        if (w_ringing && (r_ring_cnt == RING_W'(RING_CYC - 1))) w_sil_nxt = 1'b1;
        if ((r_state == ST_RUN) && w_ringing && (w_ok || w_snooze)) w_sil_nxt = 1'b1;
        if ((r_state == ST_RUN) && w_ok && !w_ringing) w_alm_en_nxt = ~r_alm_en;
        if (w_ok && w_is_alm) begin
            w_alm_en_nxt = 1'b1;
            w_sil_nxt    = 1'b0;
        end
    end

    // Shadows, load outputs, alarm registers and ring status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_hour  <= '0;
            r_sh_min   <= '0;
            r_sh_sec   <= '0;
            r_ash_hour <= '0;
            r_ash_min  <= '0;
            r_alm_hour <= '0;
            r_alm_min  <= '0;
            r_set_hour <= '0;
            r_set_min  <= '0;
            r_set_sec  <= '0;
            r_finish   <= 1'b0;
            r_alm_en   <= 1'b0;
            r_silence  <= 1'b0;
            r_clock_en <= 1'b0;
            r_buzzer   <= 1'b0;
            r_ring_cnt <= '0;
        end else begin
            r_finish <= 1'b0;
            if (w_ok && w_is_set) begin
                r_set_hour <= r_sh_hour;
                r_set_min  <= r_sh_min;
                r_set_sec  <= r_sh_sec;
                r_finish   <= 1'b1;
            end
            if (w_ok && w_is_alm) begin
                r_alm_hour <= r_ash_hour;
                r_alm_min  <= r_ash_min;
            end
            if (w_mode && (r_state == ST_RUN)) begin
                r_sh_hour <= {cur_hour_shi, cur_hour_ge};
                r_sh_min  <= {cur_min_shi, cur_min_ge};
                r_sh_sec  <= {cur_sec_shi, cur_sec_ge};
            end
            if (w_mode && (r_state == ST_SET_SEC)) begin
                r_ash_hour <= r_alm_hour;
                r_ash_min  <= r_alm_min;
            end
            if (w_inc) begin
                case (r_state)
                    ST_SET_HOUR: r_sh_hour  <= w_fld_inc;
                    ST_SET_MIN:  r_sh_min   <= w_fld_inc;
                    ST_SET_SEC:  r_sh_sec   <= w_fld_inc;
                    ST_ALM_HOUR: r_ash_hour <= w_fld_inc;
                    ST_ALM_MIN:  r_ash_min  <= w_fld_inc;
                    default:     ;
                endcase
            end
            r_alm_en   <= w_alm_en_nxt;
            r_silence  <= w_sil_nxt;
            r_clock_en <= w_alm_en_nxt & ~w_sil_nxt;
            r_buzzer   <= w_ringing;
            if (!w_ringing || (r_ring_cnt == RING_W'(RING_CYC - 1))) r_ring_cnt <= '0;
            else                                                    r_ring_cnt <= r_ring_cnt + RING_W'(1);
        end
    end

    // Edit blink; phase restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick  <= '0;
            r_blink <= 1'b0;
        end else if ((w_next != r_state) || (r_state == ST_RUN)) begin
            r_tick  <= '0;
            r_blink <= 1'b0;
        end else if (r_tick == BLINK_W'(BLINK_CYC - 1)) begin
            r_tick  <= '0;
            r_blink <= ~r_blink;
        end else begin
            r_tick <= r_tick + BLINK_W'(1);
        end
    end

`ifdef CLOCK_SNOOZE_EN
    bcd2_t      r_eff_hour, r_eff_min;
    bcd2_t      w_sn_hour, w_sn_min, w_sn_hour_inc;
    logic [4:0] w_sn_sum;

    assign w_snooze = w_inc & (r_state == ST_RUN) & w_ringing;

    bcd_wrap_inc u_snooze_hour (
        .i_tens     (r_alm_hour.shi),
        .i_ones     (r_alm_hour.ge),
        .i_max_tens (HOUR_MAX_BCD.shi),
        .i_max_ones (HOUR_MAX_BCD.ge),
        .o_tens     (w_sn_hour_inc.shi),
        .o_ones     (w_sn_hour_inc.ge)
    );

    // User alarm + SNOOZE_MIN minutes, carrying into the hour past :59.
    always_comb begin
        w_sn_sum     = {1'b0, r_alm_min.ge} + 5'(SNOOZE_MIN);
        w_sn_min.shi = r_alm_min.shi;
        w_sn_min.ge  = w_sn_sum[3:0];
        w_sn_hour    = r_alm_hour;
        if (w_sn_sum > 5'd9) begin
            w_sn_min.ge  = 4'(w_sn_sum - 5'd10);
            w_sn_min.shi = r_alm_min.shi + 4'd1;
        end
        if (w_sn_min.shi == (MIN_MAX_BCD.shi + 4'd1)) begin
            w_sn_min.shi = 4'd0;
            w_sn_hour    = w_sn_hour_inc;
        end
    end

    // Effective alarm: snoozed value until the next ring start or commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eff_hour <= '0;
            r_eff_min  <= '0;
        end else if (w_ok && w_is_alm) begin
            r_eff_hour <= r_ash_hour;
            r_eff_min  <= r_ash_min;
        end else if (w_snooze) begin
            r_eff_hour <= w_sn_hour;
            r_eff_min  <= w_sn_min;
        end else if (w_ringing && !r_buzzer) begin
            r_eff_hour <= r_alm_hour;
            r_eff_min  <= r_alm_min;
        end
    end

    assign clock_hour_shi = r_eff_hour.shi;
    assign clock_hour_ge  = r_eff_hour.ge;
    assign clock_min_shi  = r_eff_min.shi;
    assign clock_min_ge   = r_eff_min.ge;
`else
    assign w_snooze       = 1'b0;
    assign clock_hour_shi = r_alm_hour.shi;
    assign clock_hour_ge  = r_alm_hour.ge;
    assign clock_min_shi  = r_alm_min.shi;
    assign clock_min_ge   = r_alm_min.ge;
`endif

    assign set_time_finish = r_finish;
    assign set_hour_shi    = r_set_hour.shi;
    assign set_hour_ge     = r_set_hour.ge;
    assign set_min_shi     = r_set_min.shi;
    assign set_min_ge      = r_set_min.ge;
    assign set_sec_shi     = r_set_sec.shi;
    assign set_sec_ge      = r_set_sec.ge;
    assign clock_en        = r_clock_en;
    assign edit_field      = r_state;
    assign blink           = r_blink;
    assign buzzer          = r_buzzer;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed steps plus randomized edit
// sessions checked against an integer-arithmetic model of the clock rules.
`timescale 1ns/1ps
module tb_clock_set_ctrl;

    localparam int unsigned TPS  = 10;
    localparam int unsigned RSEC = 3;
    localparam int unsigned SNZ  = 5;
    localparam int unsigned QTR  = TPS / 4;

    logic clk = 1'b0;
    logic rst_n, key_mode, key_inc, key_ok, alarm_n;
    logic [3:0] cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge, cur_sec_shi, cur_sec_ge;
    logic set_time_finish, clock_en, blink, buzzer;
    logic [3:0] set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge;
    logic [3:0] clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge;
    logic [2:0] edit_field;

    always #5 clk = ~clk;

    clock_set_ctrl #(.TICKS_PER_SEC(TPS), .RING_SEC(RSEC), .SNOOZE_MIN(SNZ)) dut (
        .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_inc(key_inc), .key_ok(key_ok),
        .cur_hour_shi(cur_hour_shi), .cur_hour_ge(cur_hour_ge),
        .cur_min_shi(cur_min_shi), .cur_min_ge(cur_min_ge),
        .cur_sec_shi(cur_sec_shi), .cur_sec_ge(cur_sec_ge),
        .alarm_n(alarm_n), .set_time_finish(set_time_finish),
        .set_hour_shi(set_hour_shi), .set_hour_ge(set_hour_ge),
        .set_min_shi(set_min_shi), .set_min_ge(set_min_ge),
        .set_sec_shi(set_sec_shi), .set_sec_ge(set_sec_ge),
        .clock_en(clock_en),
        .clock_hour_shi(clock_hour_shi), .clock_hour_ge(clock_hour_ge),
        .clock_min_shi(clock_min_shi), .clock_min_ge(clock_min_ge),
        .edit_field(edit_field), .blink(blink), .buzzer(buzzer)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain integers for every field.
    int c_h, c_m, c_s;
    int m_st, m_sh_h, m_sh_m, m_sh_s, m_ash_h, m_ash_m, m_alm_h, m_alm_m;
    int m_eff_h, m_eff_m, m_set_h, m_set_m, m_set_s;
    bit m_en, m_sil, m_fin;

    function automatic logic [31:0] bcd_hm(input int h, input int m);
        return 32'({4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)});
    endfunction

    function automatic logic [31:0] bcd_hms(input int h, input int m, input int s);
        return 32'({4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"}, 32'(edit_field), 32'(m_st));
        check({tag, ".set"}, 32'({set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge}),
              bcd_hms(m_set_h, m_set_m, m_set_s));
        check({tag, ".finish"}, 32'(set_time_finish), 32'(m_fin));
        check({tag, ".clock_en"}, 32'(clock_en), 32'(m_en && !m_sil));
        check({tag, ".alarm"}, 32'({clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge}),
              bcd_hm(m_eff_h, m_eff_m));
    endtask

    task automatic m_reset();
        m_st = 0; m_sh_h = 0; m_sh_m = 0; m_sh_s = 0; m_ash_h = 0; m_ash_m = 0;
        m_alm_h = 0; m_alm_m = 0; m_eff_h = 0; m_eff_m = 0;
        m_set_h = 0; m_set_m = 0; m_set_s = 0; m_en = 0; m_sil = 0; m_fin = 0;
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        c_h = h; c_m = m; c_s = s;
        cur_hour_shi = 4'(h / 10); cur_hour_ge = 4'(h % 10);
        cur_min_shi  = 4'(m / 10); cur_min_ge  = 4'(m % 10);
        cur_sec_shi  = 4'(s / 10); cur_sec_ge  = 4'(s % 10);
        if (m_sil && (m != m_alm_m)) m_sil = 0;
    endtask

    // Model of one key cycle; called in the cycle the keys are presented.
    task automatic m_apply(input bit mo, input bit in, input bit ok);
        bit ring;
        int t;
        ring  = !alarm_n && m_en && !m_sil;
        m_fin = 0;
        if (ok) begin
            if (m_st >= 1 && m_st <= 3) begin
                m_set_h = m_sh_h; m_set_m = m_sh_m; m_set_s = m_sh_s; m_fin = 1;
            end else if (m_st >= 4) begin
                m_alm_h = m_ash_h; m_alm_m = m_ash_m; m_eff_h = m_ash_h; m_eff_m = m_ash_m;
                m_en = 1; m_sil = 0;
            end else if (ring) begin
                m_sil = 1;
            end else begin
                m_en = !m_en;
            end
            m_st = 0;
        end else if (mo) begin
            if (m_st == 0) begin m_sh_h = c_h; m_sh_m = c_m; m_sh_s = c_s; end
            if (m_st == 3) begin m_ash_h = m_alm_h; m_ash_m = m_alm_m; end
            m_st = (m_st + 1) % 6;
        end else if (in) begin
            case (m_st)
                1: m_sh_h  = (m_sh_h + 1) % 24;
                2: m_sh_m  = (m_sh_m + 1) % 60;
                3: m_sh_s  = (m_sh_s + 1) % 60;
                4: m_ash_h = (m_ash_h + 1) % 24;
                5: m_ash_m = (m_ash_m + 1) % 60;
                default: begin
`ifdef CLOCK_SNOOZE_EN
                    if (ring) begin
                        m_sil = 1;
                        t = (m_alm_h * 60 + m_alm_m + int'(SNZ)) % 1440;
                        m_eff_h = t / 60; m_eff_m = t % 60;
                    end
`endif
                    t = 0;
                end
            endcase
        end
    endtask

    task automatic press(input bit mo, input bit in, input bit ok);
        @(negedge clk);
        key_mode = mo; key_inc = in; key_ok = ok;
        m_apply(mo, in, ok);
        @(negedge clk);
        key_mode = 1'b0; key_inc = 1'b0; key_ok = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        m_fin = 0;
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) press(1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_alarm(input int h, input int m);
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0);
        while (m_ash_h != h) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        while (m_ash_m != m) press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; key_mode = 1'b0; key_inc = 1'b0; key_ok = 1'b0; alarm_n = 1'b1;
        m_reset();
        set_cur(0, 0, 0);
        #12;
        check_all("reset");
        check("reset.buzzer", 32'(buzzer), 32'd0);
        check("reset.blink", 32'(blink), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        step();

        // 09:59:58, hour +2, commit
        set_cur(9, 59, 58);
        press(1'b1, 1'b0, 1'b0);
        check_all("enter_set");
        for (int k = 0; k < 8; k++) begin
            check("blink", 32'(blink), 32'((k / int'(QTR)) % 2));
            @(negedge clk);
        end
        press_inc(2);
        press(1'b0, 1'b0, 1'b1);
        check_all("commit_time");
        check("commit_time.value", 32'({set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge}),
              bcd_hms(11, 59, 58));
        check("commit_time.finish1", 32'(set_time_finish), 32'd1);
        step();
        check_all("after_commit");
        check("run.blink", 32'(blink), 32'd0);

        // Field wrap boundaries
        set_cur(23, 59, 10);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press_inc(1);
        press(1'b0, 1'b0, 1'b1);
        check("min_wrap", 32'({set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge}),
              bcd_hms(23, 0, 10));
        press(1'b1, 1'b0, 1'b0);
        press_inc(1);
        press(1'b0, 1'b0, 1'b1);
        check("hour_wrap", 32'({set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge}),
              bcd_hms(0, 59, 10));
        check_all("hour_wrap");

        // Key priority
        set_cur(12, 34, 56);
        press(1'b1, 1'b1, 1'b0);
        check_all("mode_over_inc");
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b1);
        check_all("ok_over_mode");
        check("ok_over_mode.value", 32'({set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge}),
              bcd_hms(12, 34, 56));
        step();

        // Randomized edit sessions
        for (int it = 0; it < 8; it++) begin
            int sel;
            set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
            press(1'b1, 1'b0, 1'b0);
            press_inc(int'($urandom_range(0, 26)));
            press(1'b1, 1'b0, 1'b0);
            press_inc(int'($urandom_range(0, 62)));
            press(1'b1, 1'b0, 1'b0);
            press_inc(int'($urandom_range(0, 62)));
            sel = int'($urandom_range(0, 2));
            if (sel == 0) begin
                press(1'b0, 1'b0, 1'b1);
            end else if (sel == 1) begin
                press(1'b1, 1'b0, 1'b0);
                press_inc(int'($urandom_range(0, 26)));
                press(1'b1, 1'b0, 1'b0);
                press_inc(int'($urandom_range(0, 62)));
                press(1'b0, 1'b0, 1'b1);
            end else begin
                for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0);
            end
            check_all($sformatf("rand%0d", it));
            step();
        end

        // Alarm 07:30, ring, manual silence
        set_cur(6, 0, 0);
        set_alarm(7, 30);
        check_all("alarm_commit");
        set_cur(7, 30, 0);
        alarm_n = 1'b0;
        step();
        check("ring.buzzer", 32'(buzzer), 32'd1);
        press(1'b0, 1'b0, 1'b1);
        check_all("silenced");
        step();
        check("silenced.buzzer", 32'(buzzer), 32'd0);
        step(); step(); step();
        check_all("still_silenced");
        set_cur(7, 31, 0);
        alarm_n = 1'b1;
        step();
        check_all("silence_release");
        check("silence_release.buzzer", 32'(buzzer), 32'd0);

        // Auto-silence after RING_SEC seconds
        set_cur(7, 30, 0);
        alarm_n = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (buzzer) cnt++;
            else if (cnt > 0) break;
        end
        check("auto_silence.cycles", 32'(cnt), 32'(TPS * RSEC));
        m_sil = 1;
        check_all("auto_silence");
        set_cur(7, 31, 0);
        alarm_n = 1'b1;
        step();
        check_all("auto_release");

        // Enable toggle in RUN while not ringing
        press(1'b0, 1'b0, 1'b1);
        check_all("toggle_off");
        set_cur(7, 30, 0);
        alarm_n = 1'b0;
        step(); step();
        check("disabled.buzzer", 32'(buzzer), 32'd0);
        alarm_n = 1'b1;
        set_cur(7, 31, 0);
        press(1'b0, 1'b0, 1'b1);
        check_all("toggle_on");

        // Ringing during edit: only RUN-state ok silences
        set_cur(7, 30, 0);
        alarm_n = 1'b0;
        step();
        press(1'b1, 1'b0, 1'b0);
        check("edit_ring.buzzer", 32'(buzzer), 32'd1);
        press(1'b0, 1'b0, 1'b1);
        check_all("edit_ring.commit");
        check("edit_ring.buzzer2", 32'(buzzer), 32'd1);
        press(1'b0, 1'b0, 1'b1);
        check_all("edit_ring.silence");
        set_cur(7, 31, 0);
        alarm_n = 1'b1;
        step();
        check_all("edit_ring.release");

        // key_inc while ringing at 23:57
        set_alarm(23, 57);
        set_cur(23, 57, 0);
        alarm_n = 1'b0;
        step();
        press(1'b0, 1'b1, 1'b0);
        check_all("ring_inc");
`ifdef CLOCK_SNOOZE_EN
        check("snooze.alarm", 32'({clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge}), 32'h0002);
        step();
        check("snooze.buzzer", 32'(buzzer), 32'd0);
        set_cur(23, 58, 0);
        alarm_n = 1'b1;
        step();
        check_all("snooze.release");
        set_alarm(23, 57);
        check_all("snooze.restore");
`else
        step();
        check("no_snooze.buzzer", 32'(buzzer), 32'd1);
        press(1'b0, 1'b0, 1'b1);
        set_cur(23, 58, 0);
        alarm_n = 1'b1;
        step();
        check_all("no_snooze.release");
`endif

        // Reset in the middle of SET_SEC
        set_cur(15, 45, 30);
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0);
        press_inc(3);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_all("mid_reset");
        check("mid_reset.buzzer", 32'(buzzer), 32'd0);
        check("mid_reset.blink", 32'(blink), 32'd0);
        @(negedge clk);
        check("mid_reset.no_strobe", 32'(set_time_finish), 32'd0);
        rst_n = 1'b1;
        step(); step();
        check_all("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
